// File: rtl/adder_int.sv
// Registered integer adder: ADD, SUB and ADDI with a 21-bit sign-extended immediate.
// One-cycle latency. add_value is cleared asynchronously while reset is low.
module adder_int #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            add_type,
  input  logic [DATA_WIDTH-1:0] src1,
  input  logic [DATA_WIDTH-1:0] src2,
  input  logic [20:0]           immediate,
  output logic [DATA_WIDTH-1:0] add_value
);

  localparam logic [1:0] CTRL_ADD  = 2'b00;
  localparam logic [1:0] CTRL_SUB  = 2'b01;
  localparam logic [1:0] CTRL_ADDI = 2'b10;

  logic [DATA_WIDTH-1:0] imm_ext;
  logic [DATA_WIDTH-1:0] next_value;

  assign imm_ext = {{(DATA_WIDTH-21){immediate[20]}}, immediate};

  // Subtraction is done as a two's-complement add. The reserved code yields zero.
  always_comb begin
    next_value = '0;
    case (add_type)
      CTRL_ADD:  next_value = src1 + src2;
      CTRL_SUB:  next_value = src1 + ~src2 + DATA_WIDTH'(1);
      CTRL_ADDI: next_value = src1 + imm_ext;
      default:   next_value = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      add_value <= '0;
    else
      add_value <= next_value;
  end

endmodule

// File: tb/tb_adder_int.sv
// Randomised scoreboard bench for adder_int. Stimulus pushes the expected results,
// and a monitor pops and compares them after every clock edge.
module tb_adder_int;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic [1:0]   add_type;
  logic [W-1:0] src1;
  logic [W-1:0] src2;
  logic [20:0]  immediate;
  logic [W-1:0] add_value;

  int check_count = 0;
  int error_count = 0;
  logic [W-1:0] expected_q[$];

  adder_int #(.DATA_WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .add_type  (add_type),
    .src1      (src1),
    .src2      (src2),
    .immediate (immediate),
    .add_value (add_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model built from the arithmetic rules, using signed integers for the immediate.
  function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b, input logic [20:0] imm);
    longint imm_val;
    longint sum;
    imm_val = longint'($signed(imm));
    case (op)
      2'd0:    sum = longint'(a) + longint'(b);
      2'd1:    sum = longint'(a) - longint'(b);
      2'd2:    sum = longint'(a) + imm_val;
      default: sum = 0;
    endcase
    return sum[W-1:0];
  endfunction

  task automatic check_output(input string name, input logic [W-1:0] actual,
                              input logic [W-1:0] required);
    check_count++;
    if (actual !== required) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, actual, required);
    end
  endtask

  task automatic apply_stimulus(input logic [1:0] op, input logic [W-1:0] a,
                                input logic [W-1:0] b, input logic [20:0] imm);
    @(negedge clk);
    add_type  = op;
    src1      = a;
    src2      = b;
    immediate = imm;
    expected_q.push_back(model(op, a, b, imm));
  endtask

  // Monitor: the result is valid after every edge while reset is high.
  always @(posedge clk) begin
    #1;
    if (reset && expected_q.size() > 0)
      check_output("result", add_value, expected_q.pop_front());
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0;
    add_type = 2'b00; src1 = '0; src2 = '0; immediate = '0;
    #3;
    check_output("reset_state", add_value, '0);
    @(posedge clk); #1;
    check_output("reset_hold", add_value, '0);
    @(negedge clk);
    reset = 1'b1;

    apply_stimulus(2'b00, 32'd15, 32'd10, 21'd0);
    apply_stimulus(2'b01, 32'd20, 32'd5, 21'd0);
    apply_stimulus(2'b01, 32'd0, 32'd1, 21'd0);
    apply_stimulus(2'b10, 32'd10, 32'd0, 21'd5);
    apply_stimulus(2'b10, 32'd0, 32'hDEAD_BEEF, 21'h1FFFFF);
    apply_stimulus(2'b00, 32'hFFFF_FFFF, 32'd1, 21'd0);
    apply_stimulus(2'b00, 32'd100, 32'd23, 21'h1FFFFF);
    apply_stimulus(2'b11, 32'h1234_5678, 32'h0000_0001, 21'h00ABC);
    apply_stimulus(2'b10, 32'h8000_0000, 32'd7, 21'h100000);

    for (int i = 0; i < 200; i++)
      apply_stimulus(2'($urandom_range(0, 3)), $urandom, $urandom, 21'($urandom));

    // Inputs changed mid-cycle must not show on add_value until the next edge.
    apply_stimulus(2'b00, 32'd1, 32'd2, 21'd0);
    @(posedge clk); #2;
    src1 = 32'd100;
    immediate = 21'h0F0F0;
    expected_q.push_back(model(2'b00, 32'd100, 32'd2, 21'h0F0F0));
    #1;
    check_output("mid_cycle_hold", add_value, 32'd3);
    @(posedge clk);

    // Asynchronous reset in the middle of the stream.
    apply_stimulus(2'b00, 32'd15, 32'd10, 21'd0);
    @(posedge clk); #2;
    check_output("pre_reset_value", add_value, 32'd25);
    reset = 1'b0;
    #1;
    check_output("async_reset", add_value, '0);
    apply_stimulus(2'b01, 32'd9, 32'd4, 21'd0);
    expected_q.delete();
    @(posedge clk); #1;
    check_output("reset_discard", add_value, '0);
    @(negedge clk);
    reset = 1'b1;
    add_type = 2'b00; src1 = 32'd3; src2 = 32'd4; immediate = 21'd0;
    expected_q.push_back(model(2'b00, 32'd3, 32'd4, 21'd0));
    @(posedge clk); #2;
    check_output("after_release", add_value, 32'd7);

    for (int i = 0; i < 50; i++)
      apply_stimulus(2'($urandom_range(0, 3)), $urandom, $urandom, 21'($urandom));

    repeat (3) @(posedge clk);
    #2;
    check_output("queue_drained", 32'(expected_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule

// File: doc/adder_int.md
ADDER_INT -- requirements
Module: adder_int

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the width of the operands and the result.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, with the ports named clk and reset.
REQ-003 Port clk SHALL be an input, 1 bit wide, and SHALL be the only clock; all state changes on its rising edge.
REQ-004 Port reset SHALL be an input, 1 bit wide, asynchronous and active-low (0 = reset asserted).
REQ-005 Port add_type SHALL be an input, 2 bits wide, selecting the operation.
REQ-006 Port src1 SHALL be an input, DATA_WIDTH bits wide, carrying the first operand.
REQ-007 Port src2 SHALL be an input, DATA_WIDTH bits wide, carrying the second register operand.
REQ-008 Port immediate SHALL be an input, 21 bits wide, carrying the immediate operand as a two's-complement value.
REQ-009 Port add_value SHALL be an output, DATA_WIDTH bits wide, driven directly from a register and carrying the result.

Function
REQ-010 The add_type encodings SHALL follow the shared execution parameter header: CTRL_ADD = 2'b00, CTRL_SUB = 2'b01, CTRL_ADDI = 2'b10; 2'b11 is reserved.
REQ-011 For CTRL_ADD, the next add_value SHALL be src1 + src2.
REQ-012 For CTRL_SUB, the next add_value SHALL be src1 - src2, computed as src1 + ~src2 + 1.
REQ-013 For CTRL_ADDI, the next add_value SHALL be src1 + sext(immediate).
REQ-014 sext SHALL replicate immediate[20] into bits DATA_WIDTH-1:21.
REQ-015 For the reserved code 2'b11, the next add_value SHALL be 0.
REQ-016 All arithmetic SHALL be modulo 2^DATA_WIDTH: carry-out and overflow are discarded, and no flags or exceptions are produced.
REQ-017 Signed and unsigned interpretation SHALL give the same bit pattern; the block makes no distinction between them.
REQ-018 Latency SHALL be one clock: inputs are sampled on a rising edge of clk, and the result appears on add_value right after that edge.
REQ-019 add_value SHALL hold its value between edges, with no combinational path from inputs to add_value.
REQ-020 The block SHALL compute a new result on every clock edge while reset is deasserted; there is no enable or handshake, and the result is always valid.
REQ-021 Inputs that change between edges SHALL have no effect until the next rising edge.
REQ-022 Fields unused by the selected operation (immediate for ADD/SUB, src2 for ADDI) SHALL NOT affect the result.

Reset
REQ-023 While reset = 0, add_value SHALL be forced to 0 immediately, without waiting for a clock edge, and SHALL stay 0 for as long as reset is low.
REQ-024 A reset asserted in the middle of a stream of operations SHALL discard the pending result; no partial state survives.
REQ-025 After reset returns to 1, the first rising edge of clk SHALL load the result of the inputs present at that edge.
REQ-026 The reset-release edge SHALL be treated as synchronized to clk by the integrating level; no internal synchronizer is required.

Verification
REQ-027 Scenario ADD: src1 = 15, src2 = 10, add_type = 2'b00, then one rising edge -> add_value = 25.
REQ-028 Scenario SUB: src1 = 20, src2 = 5, add_type = 2'b01 -> add_value = 15; and src1 = 0, src2 = 1 -> add_value = 0xFFFFFFFF.
REQ-029 Scenario ADDI: src1 = 10, immediate = 5, add_type = 2'b10 -> add_value = 15; and src1 = 0, immediate = 21'h1FFFFF -> add_value = 0xFFFFFFFF (sign extension).
REQ-030 Scenario wrap and unused fields: ADD with src1 = 0xFFFFFFFF, src2 = 1 -> add_value = 0; ADD with immediate = 21'h1FFFFF applied -> result unchanged by immediate.
REQ-031 Scenario reset: with add_value = 25, drive reset low between clock edges -> add_value = 0 before the next edge; then release reset with ADD 3 + 4 applied -> add_value = 7 after the first edge.
REQ-032 Scenario reserved code and latency: add_type = 2'b11 -> add_value = 0; changing inputs in the middle of a cycle -> add_value changes only at the next rising edge.
